// File: rtl/conv_rd_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : conv_rd_addr_gen
//  Brief    : Walks every K x K x CH_GRP window of a plane and issues the
//             feature-map and weight read addresses for each window tap.
//  Revision : 1.0
// ============================================================================
module conv_rd_addr_gen #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int CH_GRP = 1,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] fm_addr,
    output logic [ADDR_W-1:0] wt_addr,
    output logic              pad,
    output logic              last_tap,
    output logic              last_pix,
    output logic [ADDR_W-1:0] pix_idx,
    output logic              done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_FIN   = 2'd2;

    localparam int c_P  = K / 2;
    localparam int c_XW = (K > 1)      ? $clog2(K)      : 1;
    localparam int c_GW = (CH_GRP > 1) ? $clog2(CH_GRP) : 1;
    localparam int c_CW = (IMG_W > 1)  ? $clog2(IMG_W)  : 1;
    localparam int c_RW = (IMG_H > 1)  ? $clog2(IMG_H)  : 1;

    localparam logic [c_XW-1:0] c_K_MAX = c_XW'(K - 1);
    localparam logic [c_GW-1:0] c_G_MAX = c_GW'(CH_GRP - 1);
    localparam logic [c_CW-1:0] c_C_MAX = c_CW'(IMG_W - 1);
    localparam logic [c_RW-1:0] c_R_MAX = c_RW'(IMG_H - 1);

    localparam logic signed [ADDR_W:0] c_PAD_S = (ADDR_W+1)'(c_P);
    localparam logic signed [ADDR_W:0] c_H_S   = (ADDR_W+1)'(IMG_H);
    localparam logic signed [ADDR_W:0] c_W_S   = (ADDR_W+1)'(IMG_W);

    localparam logic [ADDR_W-1:0] c_W_A     = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] c_PLANE_A = ADDR_W'(IMG_W * IMG_H);
    localparam logic [ADDR_W-1:0] c_KK_A    = ADDR_W'(K * K);
    localparam logic [ADDR_W-1:0] c_K_A     = ADDR_W'(K);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    // Counters name the beat that will be presented on the next load.
    logic [c_XW-1:0]   r_kx;
    logic [c_XW-1:0]   r_ky;
    logic [c_GW-1:0]   r_g;
    logic [c_CW-1:0]   r_c;
    logic [c_RW-1:0]   r_r;

    logic              r_busy;
    logic              r_valid;
    logic              r_done;
    logic [ADDR_W-1:0] r_fm_addr;
    logic [ADDR_W-1:0] r_wt_addr;
    logic [ADDR_W-1:0] r_pix_idx;
    logic              r_pad;
    logic              r_last_tap;
    logic              r_last_pix;

    logic signed [ADDR_W:0] w_row;
    logic signed [ADDR_W:0] w_col;
    logic              w_pad;
    logic [ADDR_W-1:0] w_fm;
    logic [ADDR_W-1:0] w_wt;
    logic [ADDR_W-1:0] w_pix;
    logic              w_last_tap;
    logic              w_last_pix;
    logic              w_fire;
    logic              w_load;

    assign w_fire = r_valid & rd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_fire && r_last_pix) begin
                    w_state_nxt = S_FIN;
                end else if (!r_valid || w_fire) begin
                    w_load = 1'b1;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Tap position relative to the plane; negative means top/left padding.
    assign w_row = (ADDR_W+1)'(r_r) + (ADDR_W+1)'(r_ky) - c_PAD_S;
    assign w_col = (ADDR_W+1)'(r_c) + (ADDR_W+1)'(r_kx) - c_PAD_S;

    assign w_pad = w_row[ADDR_W] | w_col[ADDR_W] | (w_row >= c_H_S) | (w_col >= c_W_S);

    assign w_fm = w_pad ? '0
                : (ADDR_W'(r_g) * c_PLANE_A + w_row[ADDR_W-1:0] * c_W_A + w_col[ADDR_W-1:0]);
    assign w_wt  = ADDR_W'(r_g) * c_KK_A + ADDR_W'(r_ky) * c_K_A + ADDR_W'(r_kx);
    assign w_pix = ADDR_W'(r_r) * c_W_A + ADDR_W'(r_c);

    assign w_last_tap = (r_g == c_G_MAX) && (r_ky == c_K_MAX) && (r_kx == c_K_MAX);
    assign w_last_pix = w_last_tap && (r_r == c_R_MAX) && (r_c == c_C_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kx       <= '0;
            r_ky       <= '0;
            r_g        <= '0;
            r_c        <= '0;
            r_r        <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_fm_addr  <= '0;
            r_wt_addr  <= '0;
            r_pix_idx  <= '0;
            r_pad      <= 1'b0;
            r_last_tap <= 1'b0;
            r_last_pix <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_FIN);

            if (r_state == S_IDLE && start) begin
                r_kx <= '0;
                r_ky <= '0;
                r_g  <= '0;
                r_c  <= '0;
                r_r  <= '0;
            end

            if (w_load) begin
                r_valid    <= 1'b1;
                r_fm_addr  <= w_fm;
                r_wt_addr  <= w_wt;
                r_pix_idx  <= w_pix;
                r_pad      <= w_pad;
                r_last_tap <= w_last_tap;
                r_last_pix <= w_last_pix;

                // Loop nest, innermost first: kx, ky, g, c, r.
                if (r_kx != c_K_MAX) begin
                    r_kx <= r_kx + 1'b1;
                end else begin
                    r_kx <= '0;
                    if (r_ky != c_K_MAX) begin
                        r_ky <= r_ky + 1'b1;
                    end else begin
                        r_ky <= '0;
                        if (r_g != c_G_MAX) begin
                            r_g <= r_g + 1'b1;
                        end else begin
                            r_g <= '0;
                            if (r_c != c_C_MAX) begin
                                r_c <= r_c + 1'b1;
                            end else begin
                                r_c <= '0;
                                if (r_r != c_R_MAX) begin
                                    r_r <= r_r + 1'b1;
                                end else begin
                                    r_r <= '0;
                                end
                            end
                        end
                    end
                end
            end else if (w_fire) begin
                // Final beat accepted: drop the beat flags for the FIN cycle.
                r_valid    <= 1'b0;
                r_last_tap <= 1'b0;
                r_last_pix <= 1'b0;
            end
        end
    end

    assign busy     = r_busy;
    assign rd_valid = r_valid;
    assign done     = r_done;
    assign fm_addr  = r_fm_addr;
    assign wt_addr  = r_wt_addr;
    assign pix_idx  = r_pix_idx;
    assign pad      = r_pad;
    assign last_tap = r_last_tap;
    assign last_pix = r_last_pix;

endmodule
`default_nettype wire

// File: tb/tb_conv_rd_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_rd_addr_gen
//  Brief    : Directed and randomized-handshake bench for conv_rd_addr_gen.
//  Revision : 1.0
// ============================================================================
module tb_conv_rd_addr_gen;

    localparam int c_W     = 28;
    localparam int c_H     = 28;
    localparam int c_K     = 5;
    localparam int c_BEATS = c_W * c_H * c_K * c_K;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, rd_ready;
    logic        busy, rd_valid, pad, last_tap, last_pix, done;
    logic [15:0] fm_addr, wt_addr, pix_idx;
    logic        start_2, rd_ready_2;
    logic        busy_2, rd_valid_2, pad_2, last_tap_2, last_pix_2, done_2;
    logic [15:0] fm_addr_2, wt_addr_2, pix_idx_2;

    int checks = 0;
    int errors = 0;
    int n, cyc, nlt, nunpad0;

    always #5 clk = ~clk;

    conv_rd_addr_gen dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .fm_addr(fm_addr), .wt_addr(wt_addr), .pad(pad),
        .last_tap(last_tap), .last_pix(last_pix), .pix_idx(pix_idx), .done(done)
    );

    conv_rd_addr_gen #(.CH_GRP(2)) dut_2 (
        .clk(clk), .rst(rst), .start(start_2), .busy(busy_2),
        .rd_valid(rd_valid_2), .rd_ready(rd_ready_2),
        .fm_addr(fm_addr_2), .wt_addr(wt_addr_2), .pad(pad_2),
        .last_tap(last_tap_2), .last_pix(last_pix_2), .pix_idx(pix_idx_2), .done(done_2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: beat n decomposed directly into pixel / group / tap coordinates.
    task automatic check_beat(input string pfx, input int ch, input int nb,
                              input logic [15:0] o_fm, input logic [15:0] o_wt,
                              input logic [15:0] o_pix, input logic o_pad,
                              input logic o_lt, input logic o_lp);
        int taps, tap, p, g, ky, kx, r, c, row, col;
        logic e_pad;
        taps  = ch * c_K * c_K;
        tap   = nb % taps;
        p     = nb / taps;
        g     = tap / (c_K * c_K);
        ky    = (tap % (c_K * c_K)) / c_K;
        kx    = tap % c_K;
        r     = p / c_W;
        c     = p % c_W;
        row   = r + ky - c_K / 2;
        col   = c + kx - c_K / 2;
        e_pad = (row < 0) || (row >= c_H) || (col < 0) || (col >= c_W);
        chk({pfx, "_pad"}, o_pad, e_pad);
        chk({pfx, "_fm"},  o_fm,  e_pad ? 0 : g * c_H * c_W + row * c_W + col);
        chk({pfx, "_wt"},  o_wt,  g * c_K * c_K + ky * c_K + kx);
        chk({pfx, "_pix"}, o_pix, p);
        chk({pfx, "_lt"},  o_lt,  tap == taps - 1);
        chk({pfx, "_lp"},  o_lp,  (tap == taps - 1) && (p == c_H * c_W - 1));
    endtask

    task automatic check_reset(input string pfx);
        chk({pfx, "_busy"},  busy, 0);
        chk({pfx, "_valid"}, rd_valid, 0);
        chk({pfx, "_done"},  done, 0);
        chk({pfx, "_fm"},    fm_addr, 0);
        chk({pfx, "_wt"},    wt_addr, 0);
        chk({pfx, "_pad"},   pad, 0);
        chk({pfx, "_lt"},    last_tap, 0);
        chk({pfx, "_lp"},    last_pix, 0);
        chk({pfx, "_pix"},   pix_idx, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rd_ready = 1'b0; start_2 = 1'b0; rd_ready_2 = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        chk("rst_busy_2", busy_2, 0);
        chk("rst_valid_2", rd_valid_2, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Full-throughput plane
        rd_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("lat_busy", busy, 1);
        chk("lat_valid", rd_valid, 0);
        @(negedge clk);
        chk("first_valid", rd_valid, 1);
        n = 0; cyc = 0; nlt = 0; nunpad0 = 0;
        while (n < c_BEATS && cyc < 30000) begin
            if (rd_valid) begin
                check_beat("full", 1, n, fm_addr, wt_addr, pix_idx, pad, last_tap, last_pix);
                if (n == 0) begin
                    chk("b0_pix", pix_idx, 0); chk("b0_wt", wt_addr, 0);
                    chk("b0_pad", pad, 1);     chk("b0_fm", fm_addr, 0);
                end
                if (n == 12) begin
                    chk("b12_pad", pad, 0); chk("b12_fm", fm_addr, 0);
                    chk("b12_wt", wt_addr, 12); chk("b12_lt", last_tap, 0);
                end
                if (n == 24) chk("b24_lt", last_tap, 1);
                if (n == 37) chk("pix1_t12_fm", fm_addr, 1);
                if (n == 406 * 25) begin
                    chk("pix406_fm", fm_addr, 348); chk("pix406_pad", pad, 0);
                    chk("pix406_wt", wt_addr, 0);
                end
                if (n == c_BEATS - 1) begin
                    chk("lastb_pix", pix_idx, 783); chk("lastb_pad", pad, 1);
                    chk("lastb_lp", last_pix, 1);
                end
                if (last_tap) nlt++;
                if (n < 25 && !pad) nunpad0++;
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("full_beats", n, c_BEATS);
        chk("full_last_taps", nlt, 784);
        chk("pix0_unpadded", nunpad0, 9);
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 1);
        chk("fin_valid", rd_valid, 0);
        @(negedge clk);
        chk("post_busy", busy, 0);
        chk("post_done", done, 0);

        // Random back-pressure with stray start pulses mid-plane
        rd_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; cyc = 0;
        while (n < c_BEATS && cyc < 60000) begin
            if (rd_valid) begin
                check_beat("rnd", 1, n, fm_addr, wt_addr, pix_idx, pad, last_tap, last_pix);
                rd_ready = 1'($urandom_range(0, 1));
                start = ($urandom_range(0, 15) == 0);
                if (rd_ready) n++;
            end else begin
                rd_ready = 1'($urandom_range(0, 1));
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("rnd_beats", n, c_BEATS);
        chk("rnd_fin_done", done, 1);
        chk("rnd_fin_valid", rd_valid, 0);
        @(negedge clk);
        chk("rnd_post_busy", busy, 0);
        chk("rnd_post_valid", rd_valid, 0);

        // Reset at beat 500, then restart from beat 0
        rd_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n = 0; cyc = 0;
        while (n < 500 && cyc < 1000) begin
            if (rd_valid) n++;
            @(negedge clk);
            cyc++;
        end
        check_beat("b500", 1, 500, fm_addr, wt_addr, pix_idx, pad, last_tap, last_pix);
        rst = 1'b1;
        rd_ready = 1'b0;
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        rd_ready = 1'b1;
        @(negedge clk);
        chk("midrst_idle", busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", busy, 1);
        @(negedge clk);
        n = 0; cyc = 0;
        while (n < 30 && cyc < 100) begin
            if (rd_valid) begin
                check_beat("restart", 1, n, fm_addr, wt_addr, pix_idx, pad, last_tap, last_pix);
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("restart_beats", n, 30);

        // Two channel groups
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd_ready_2 = 1'b1;
        start_2 = 1'b1;
        @(negedge clk);
        start_2 = 1'b0;
        @(negedge clk);
        n = 0; cyc = 0;
        while (n < 150 && cyc < 300) begin
            if (rd_valid_2) begin
                check_beat("ch2", 2, n, fm_addr_2, wt_addr_2, pix_idx_2, pad_2, last_tap_2, last_pix_2);
                if (n == 37) begin
                    chk("ch2_g1t12_fm", fm_addr_2, 784);
                    chk("ch2_g1t12_wt", wt_addr_2, 37);
                end
                if (last_tap_2) chk("ch2_lt_pos", n % 50, 49);
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("ch2_beats", n, 150);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_rd_addr_gen.md
Name: conv_rd_addr_gen

Overview:
- Read-side address sequencer for the convolution datapath.
- For every output pixel, issues the input-feature-map and weight read addresses of one K x K window across all channel groups, with zero-padding flags.
- Issue order matches the per-neuron tap count (CH_GRP*K*K) and per-plane pixel count (R*C) that the downstream neuron/plane readiness counters expect.
- Sits between the control start pulse and the feature/weight buffer read ports.

Parameters:
- IMG_W, 28, input/output plane width C.
- IMG_H, 28, input/output plane height R.
- K, 5, kernel size (odd); padding P = K/2 (same-size output).
- CH_GRP, 1, channel groups per neuron (in_channel/4 rounded up).
- ADDR_W, 16, address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to sequence one full plane; sampled only when idle.
- busy  out  1  high from the cycle after accepted start until the cycle done pulses.
- rd_valid  out  1  address beat valid.
- rd_ready  in  1  consumer accepts beat when rd_valid & rd_ready.
- fm_addr  out  ADDR_W  feature-map address g*IMG_H*IMG_W + row*IMG_W + col; 0 when pad.
- wt_addr  out  ADDR_W  weight address g*K*K + ky*K + kx.
- pad  out  1  window tap lies outside the plane; data must be forced to 0.
- last_tap  out  1  beat is the final tap (g=CH_GRP-1, ky=kx=K-1) of the current output pixel.
- last_pix  out  1  beat is the final beat of the plane (last_tap on pixel R*C-1).
- pix_idx  out  ADDR_W  output pixel index r*IMG_W + c of the current beat.
- done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- States: IDLE, ISSUE, FIN.
  - IDLE -> ISSUE on start.
  - ISSUE -> FIN when the beat with last_pix is accepted.
  - FIN -> IDLE after one cycle (done=1 in FIN).
- Reset: state IDLE; all counters 0. Outputs: busy=0, rd_valid=0, done=0, fm_addr=0, wt_addr=0, pad=0, last_tap=0, last_pix=0, pix_idx=0.
- Latency: start sampled at edge t gives rd_valid=1 with the first beat (r=c=g=ky=kx=0) after edge t+1. All outputs are registered.
- Loop order, innermost first: kx, ky, g, c, r. All counters reset to 0 on wrap; the next outer counter increments.
- Advance only on rd_valid & rd_ready, one beat per cycle at full throughput.
- While rd_valid & !rd_ready, every output holds stable.
- Tap position: row = r+ky-P, col = c+kx-P, computed signed (ADDR_W+1 bits).
  - pad=1 if row<0, row>=IMG_H, col<0, or col>=IMG_W.
  - When pad=1, fm_addr=0; wt_addr is still valid.
- Beats per plane: IMG_H*IMG_W*CH_GRP*K*K. last_tap marks every CH_GRP*K*K-th beat.
- FIN cycle: rd_valid=0, busy=1, done=1. In the following cycle busy=0.
- start while busy or in FIN: ignored, with no queuing.
- rst mid-plane: returns to IDLE the next cycle with reset values; any partial sequence is abandoned.
- rd_ready is ignored while rd_valid=0.

Test Plan:
- Reset, then start with defaults and rd_ready=1:
  - first beat: pix_idx=0, wt_addr=0, pad=1, fm_addr=0.
  - beat 12: pad=0, fm_addr=0, wt_addr=12, last_tap=0.
  - beat 24: last_tap=1.
  - exactly 9 unpadded beats in pixel 0.
- Full plane with defaults:
  - exactly 19600 beats.
  - 784 last_tap pulses.
  - last_pix only on beat 19599 (pix_idx=783, pad=1).
  - done one cycle later; busy low the cycle after.
- Pixel 406 (r=14, c=14) tap 0 -> fm_addr=348, pad=0, wt_addr=0. Pixel 1 tap 12 -> fm_addr=1.
- Toggle rd_ready randomly (~50%) -> beat sequence identical to full-throughput run; outputs stable during every stall; total accepted beats still 19600.
- CH_GRP=2 -> pixel 0, g=1 tap 12 gives fm_addr=784, wt_addr=37; last_tap every 50 beats.
- Assert rst at beat 500, then start again -> restarts at beat 0 with reset values. A start pulsed mid-plane has no effect on the sequence.
